// File: rtl/alu_pkg.sv
// Shared types for the execute-path adder/subtractor and the set-less-than
// comparator that consumes its flags.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // Condition flags as produced by the adder and read by the comparator.
    typedef struct packed {
        logic n;
        logic v;
        logic c;
        logic z;
    } alu_flags_t;

endpackage

// File: rtl/alu_addsub_pipe_add_slice.sv
// W-bit combinational adder slice with carry in and carry out. The pipeline
// chains two of these across a register to split the carry path.
module add_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Zero-extend by one bit so the top bit of the sum is the carry out.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/alu_addsub_pipe.sv
// Two-stage pipelined adder/subtractor producing result plus N/V/C/Z flags.
// Stage 1 adds the low half; stage 2 adds the high half with the registered
// low-half carry and derives the flags. Valid/ready on both sides, one
// operation per cycle when the consumer keeps up.
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_c,
    output logic             flag_z
);

    // Low slice width is derived from WIDTH; the high slice takes the rest.
    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("alu_addsub_pipe: WIDTH must be even and >= 4");
    end

    // Operand preparation: subtraction is A + ~B + 1.
    logic [WIDTH-1:0] b_eff;
    logic             cin;

    // Handshake
    logic accept;
    logic s2_free;
    logic s1_adv;

    // Stage 1 state
    logic            s1_valid_reg;
    logic [LO_W-1:0] sum_lo_reg;
    logic            c_lo_reg;
    logic [HI_W-1:0] a_hi_reg;
    logic [HI_W-1:0] b_hi_reg;

    // Stage 1 low-slice adder outputs
    logic [LO_W-1:0] sum_lo_next;
    logic            c_lo_next;

    // Stage 2 high-slice adder outputs and next values
    logic [HI_W-1:0]  sum_hi;
    logic             c_hi;
    logic [WIDTH-1:0] result_next;
    alu_flags_t       flags_next;

    // Stage 2 state (visible outputs)
    logic             s2_valid_reg;
    logic [WIDTH-1:0] result_reg;
    alu_flags_t       flags_reg;

    assign b_eff = sub ? ~b : b;
    assign cin   = sub;

    assign s2_free  = ~s2_valid_reg | out_ready;
    assign s1_adv   = s1_valid_reg & s2_free;
    assign in_ready = ~s1_valid_reg | s2_free;
    assign accept   = in_valid & in_ready;

    add_slice #(.W(LO_W)) u_lo (
        .a    (a[LO_W-1:0]),
        .b    (b_eff[LO_W-1:0]),
        .cin  (cin),
        .sum  (sum_lo_next),
        .cout (c_lo_next)
    );

    add_slice #(.W(HI_W)) u_hi (
        .a    (a_hi_reg),
        .b    (b_hi_reg),
        .cin  (c_lo_reg),
        .sum  (sum_hi),
        .cout (c_hi)
    );

    // Stage 1 payload: low-slice sum/carry plus the high operand halves.
    always_ff @(posedge clk) begin
        if (accept) begin
            sum_lo_reg <= sum_lo_next;
            c_lo_reg   <= c_lo_next;
            a_hi_reg   <= a[WIDTH-1:LO_W];
            b_hi_reg   <= b_eff[WIDTH-1:LO_W];
        end
    end

    // Stage 2 result assembly and flag derivation.
    always_comb begin
        result_next  = {sum_hi, sum_lo_reg};
        flags_next   = '0;
        flags_next.n = sum_hi[HI_W-1];
        flags_next.c = c_hi;
        flags_next.z = ~|result_next;
        flags_next.v = (a_hi_reg[HI_W-1] == b_hi_reg[HI_W-1]) &
                       (sum_hi[HI_W-1] != a_hi_reg[HI_W-1]);
    end

    // Valid bits and visible outputs; cleared asynchronously so out_valid
    // drops the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            result_reg   <= '0;
            flags_reg    <= '0;
        end else begin
            s1_valid_reg <= accept | (s1_valid_reg & ~s2_free);
            s2_valid_reg <= s1_adv | (s2_valid_reg & ~out_ready);
            if (s1_adv) begin
                result_reg <= result_next;
                flags_reg  <= flags_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign result    = result_reg;
    assign flag_n    = flags_reg.n;
    assign flag_v    = flags_reg.v;
    assign flag_c    = flags_reg.c;
    assign flag_z    = flags_reg.z;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Scoreboard bench for alu_addsub_pipe: accepted operations push an expected
// response computed with plain integer arithmetic; a monitor pops and compares
// whenever the DUT hands a result over.
module tb_alu_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        flag_n, flag_v, flag_c, flag_z;

    alu_addsub_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .flag_c    (flag_c),
        .flag_z    (flag_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;    // {n, v, c, z}
        int          acc_cyc;
        bit          lat_chk;
    } exp_t;

    exp_t queue_exp[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_popped = 0;
    bit   lat_mode = 1'b0;
    bit   rand_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain wide unsigned and signed arithmetic.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t   e;
        longint sx, sy, sr;
        logic [32:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            e.res = x - y;
            sr    = sx - sy;
            e.fl[1] = (x >= y);
        end else begin
            u     = {1'b0, x} + {1'b0, y};
            e.res = u[31:0];
            sr    = sx + sy;
            e.fl[1] = u[32];
        end
        e.fl[3] = e.res[31];
        e.fl[2] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.fl[0] = (e.res == 32'd0);
        e.acc_cyc = 0;
        e.lat_chk = 1'b0;
        return e;
    endfunction

    // Accept side: the handshake seen at this negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_t e;
            e = model(a, b, sub);
            e.acc_cyc = cyc;
            e.lat_chk = lat_mode;
            queue_exp.push_back(e);
            $display("IN  cyc=%0d a=%08h b=%08h sub=%0b", cyc, a, b, sub);
        end
    end

    // Output side: pop and compare on every handshake; held results must not move.
    logic        held = 1'b0;
    logic [35:0] held_val;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held) check("hold_stable", {result, flag_n, flag_v, flag_c, flag_z}, held_val);
            if (out_ready) begin
                if (queue_exp.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = queue_exp.pop_front();
                    n_popped++;
                    $display("OUT cyc=%0d result=%08h nvcz=%b exp=%08h/%b", cyc, result,
                             {flag_n, flag_v, flag_c, flag_z}, e.res, e.fl);
                    check("result", result, e.res);
                    check("flags_nvcz", {flag_n, flag_v, flag_c, flag_z}, e.fl);
                    if (e.lat_chk) check("latency", cyc - e.acc_cyc, 2);
                end
            end
        end
        held     = rst_n && out_valid && !out_ready;
        held_val = {result, flag_n, flag_v, flag_c, flag_z};
    end

    // Random backpressure while rand_mode is on.
    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one operation (called at posedge+1) and wait for it to be taken.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] dir_a [7] = '{32'd5, 32'd3, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dir_b [7] = '{32'd3, 32'd5, 32'd7, 32'd1, 32'd1, 32'd1, 32'd1};
    logic        dir_s [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int popped0;
        int accepted;
        bit got;
        logic [31:0] bp_a [3];
        logic [31:0] bp_b [3];

        // Reset state
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {result, flag_n, flag_v, flag_c, flag_z}, 36'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", in_ready, 1);

        // Directed cases, isolated, latency checked
        lat_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(dir_a[i], dir_b[i], dir_s[i]);
            repeat (3) @(posedge clk);
            #1;
        end
        lat_mode = 1'b0;

        // Backpressure: three ops offered with out_ready low, only two taken
        for (int i = 0; i < 3; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = bp_a[0];
        b = bp_b[0];
        sub = 1'b0;
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            got = in_ready;
            if (got) accepted++;
            @(posedge clk);
            #1;
            if (got && accepted < 3) begin
                a = bp_a[accepted];
                b = bp_b[accepted];
                sub = accepted[0];
            end
        end
        @(negedge clk);
        check("bp_accepted", accepted, 2);
        check("bp_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        popped0 = n_popped;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_1", out_valid, 1);
        @(negedge clk);
        check("bp_drain_2", out_valid, 1);
        @(negedge clk);
        check("bp_drain_empty", out_valid, 0);
        #1;
        check("bp_drain_count", n_popped - popped0, 2);

        // Reset with both stages full
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(rnd_op(), rnd_op(), 1'b1);
        send(rnd_op(), rnd_op(), 1'b0);
        check("full_before_reset", {out_valid, in_ready}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_outputs", {result, flag_n, flag_v, flag_c, flag_z}, 36'd0);
        queue_exp.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        lat_mode = 1'b1;
        send(32'd100, 32'd42, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        lat_mode = 1'b0;

        // Randomized traffic with random gaps and backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_empty", queue_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
